// File: rtl/clock_display_pkg.sv
// Shared constants for the six-digit multiplexed 7-segment clock display.
package clock_display_pkg;

  // Active-high segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [2:0] IDX_SEC_L  = 3'd0;
  localparam logic [2:0] IDX_SEC_H  = 3'd1;
  localparam logic [2:0] IDX_MIN_L  = 3'd2;
  localparam logic [2:0] IDX_MIN_H  = 3'd3;
  localparam logic [2:0] IDX_HOUR_L = 3'd4;
  localparam logic [2:0] IDX_HOUR_H = 3'd5;

  // Decimal point acts as the field separator after minute_l and hour_l
  localparam logic [5:0] DP_MASK = 6'b010100;

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-high 7-segment pattern; non-decimal codes decode to blank.
module seg7_decode
  import clock_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (bcd)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed 7-segment scanner with field blinking during time set.
module clock_display_scan
  import clock_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLINK_HALF     = 25000000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hour_h,
  input  logic [3:0] hour_l,
  input  logic [3:0] minute_h,
  input  logic [3:0] minute_l,
  input  logic [3:0] second_h,
  input  logic [3:0] second_l,
  input  logic       set_mode,
  input  logic       set_hour,
  input  logic       set_minute,
  input  logic       set_second,
  output logic [7:0] seg,
  output logic [5:0] dig
);

  localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_HALF - 1);
  localparam logic [7:0] SegOff = {8{SEG_ACTIVE_LOW}};
  localparam logic [5:0] DigOff = {6{DIG_ACTIVE_LOW}};

  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("SCAN_DIV must be at least 2");
  end
  if (BLINK_HALF < 2) begin : g_bad_blink_half
    $error("BLINK_HALF must be at least 2");
  end

  logic [ScanW-1:0]  scan_cnt_q;
  logic              tick;
  logic              tick_q;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        slot_idx_q;
  logic [3:0]        slot_bcd_q, sel_bcd;
  logic [BlinkW-1:0] blink_cnt_q;
  logic              blink_phase_q;
  logic [6:0]        pattern;
  logic              field_flag;
  logic              blank;
  logic [7:0]        seg_d, seg_q;
  logic [5:0]        dig_d, dig_q;

  assign tick  = (scan_cnt_q == ScanLast);
  assign idx_d = (idx_q == IDX_HOUR_H) ? IDX_SEC_L : idx_q + 3'd1;

  always_comb begin
    sel_bcd = second_l;
    case (idx_q)
      IDX_SEC_L:  sel_bcd = second_l;
      IDX_SEC_H:  sel_bcd = second_h;
      IDX_MIN_L:  sel_bcd = minute_l;
      IDX_MIN_H:  sel_bcd = minute_h;
      IDX_HOUR_L: sel_bcd = hour_l;
      IDX_HOUR_H: sel_bcd = hour_h;
      default:    sel_bcd = 4'hF;
    endcase
  end

  seg7_decode u_seg7_decode (
    .bcd     (slot_bcd_q),
    .pattern (pattern)
  );

  always_comb begin
    field_flag = 1'b0;
    case (slot_idx_q)
      IDX_SEC_L,  IDX_SEC_H:  field_flag = set_second;
      IDX_MIN_L,  IDX_MIN_H:  field_flag = set_minute;
      IDX_HOUR_L, IDX_HOUR_H: field_flag = set_hour;
      default:                field_flag = 1'b0;
    endcase
  end

  // Blank sampled once per slot at the pin update edge, so it holds for the slot
  assign blank = set_mode & blink_phase_q & field_flag;

  always_comb begin
    seg_d = {DP_MASK[slot_idx_q], blank ? SEG_BLANK : pattern} ^ SegOff;
    dig_d = (6'd1 << slot_idx_q) ^ DigOff;
  end

  // The slot registers capture the index being shown and its digit at the tick edge;
  // idx then points at the next slot, and the pins follow one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_q    <= '0;
      tick_q        <= 1'b0;
      idx_q         <= IDX_SEC_L;
      slot_idx_q    <= IDX_SEC_L;
      slot_bcd_q    <= 4'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      seg_q         <= SegOff;
      dig_q         <= DigOff;
    end else begin
      scan_cnt_q <= tick ? '0 : scan_cnt_q + 1'b1;
      tick_q     <= tick;
      if (tick) begin
        slot_idx_q <= idx_q;
        slot_bcd_q <= sel_bcd;
        idx_q      <= idx_d;
      end
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
      if (tick_q) begin
        seg_q <= seg_d;
        dig_q <= dig_d;
      end
    end
  end

  assign seg = seg_q;
  assign dig = dig_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan with SCAN_DIV=4, BLINK_HALF=32, active-low pins.
module tb_clock_display_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] hour_h, hour_l, minute_h, minute_l, second_h, second_l;
  logic       set_mode, set_hour, set_minute, set_second;
  logic [7:0] seg;
  logic [5:0] dig;

  int n_cmp  = 0;
  int n_fail = 0;
  int edges;

  logic [7:0] norm [6];
  logic [5:0] digs [6];

  always #5 clk = ~clk;

  // Posedges since reset release; samples are taken on negedges
  always @(posedge clk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  clock_display_scan #(
    .SCAN_DIV       (4),
    .BLINK_HALF     (32),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hour_h     (hour_h),
    .hour_l     (hour_l),
    .minute_h   (minute_h),
    .minute_l   (minute_l),
    .second_h   (second_h),
    .second_l   (second_l),
    .set_mode   (set_mode),
    .set_hour   (set_hour),
    .set_minute (set_minute),
    .set_second (set_second),
    .seg        (seg),
    .dig        (dig)
  );

  task automatic set_time_123456();
    hour_h = 4'd1; hour_l = 4'd2; minute_h = 4'd3;
    minute_l = 4'd4; second_h = 4'd5; second_l = 4'd6;
  endtask

  task automatic restart();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_to(input int e);
    int guard;
    guard = 0;
    while (edges < e && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (edges != e) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_to: edges=%0d required %0d", edges, e);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    hour_h = 4'($urandom); hour_l = 4'($urandom); minute_h = 4'($urandom);
    minute_l = 4'($urandom); second_h = 4'($urandom); second_l = 4'($urandom);
    set_mode = 1'($urandom); set_hour = 1'($urandom);
    set_minute = 1'($urandom); set_second = 1'($urandom);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (seg !== 8'hFF) begin
      n_fail++; $display("FAIL reset_seg: got %h want ff", seg);
    end
    n_cmp++;
    if (dig !== 6'h3F) begin
      n_fail++; $display("FAIL reset_dig: got %h want 3f", dig);
    end
    set_time_123456();
    set_mode = 1'b0; set_hour = 1'b0; set_minute = 1'b0; set_second = 1'b0;
    rst = 1'b1;
    wait_to(4);
    n_cmp++;
    if (dig !== 6'h3F || seg !== 8'hFF) begin
      n_fail++; $display("FAIL reset_early: seg=%h dig=%h want ff/3f", seg, dig);
    end
    for (int k = 0; k <= 6; k++) begin
      wait_to(5 + 4 * k);
      n_cmp++;
      if (dig !== digs[k % 6]) begin
        n_fail++; $display("FAIL reset_scan%0d: dig=%h want %h", k, dig, digs[k % 6]);
      end
    end
  endtask

  task automatic test_decode();
    set_time_123456();
    set_mode = 1'b0;
    restart();
    for (int n = 0; n < 6; n++) begin
      wait_to(4 * n + 6);
      n_cmp++;
      if (seg !== norm[n] || dig !== digs[n]) begin
        n_fail++;
        $display("FAIL decode_idx%0d: seg=%h dig=%h want %h/%h", n, seg, dig, norm[n], digs[n]);
      end
    end
  endtask

  task automatic test_invalid_bcd();
    set_time_123456();
    second_l = 4'hB;
    restart();
    wait_to(6);
    n_cmp++;
    if (seg !== 8'hFF || dig !== 6'h3E) begin
      n_fail++; $display("FAIL invalid_bcd: seg=%h dig=%h want ff/3e", seg, dig);
    end
    for (int n = 1; n < 6; n++) begin
      wait_to(4 * n + 6);
      n_cmp++;
      if (seg !== norm[n]) begin
        n_fail++; $display("FAIL invalid_other%0d: seg=%h want %h", n, seg, norm[n]);
      end
    end
    second_l = 4'd6;
  endtask

  task automatic test_blink();
    int         idx;
    int         phase;
    logic [7:0] exp_seg;
    set_time_123456();
    set_mode = 1'b1; set_minute = 1'b1;
    restart();
    for (int n = 0; n < 16; n++) begin
      wait_to(4 * n + 6);
      idx     = n % 6;
      phase   = ((4 * n + 4) / 32) % 2;
      exp_seg = norm[idx];
      if (phase == 1 && (idx == 2 || idx == 3)) exp_seg = exp_seg | 8'h7F;
      n_cmp++;
      if (seg !== exp_seg || dig !== digs[idx]) begin
        n_fail++;
        $display("FAIL blink_slot%0d: seg=%h dig=%h want %h/%h", n, seg, dig, exp_seg, digs[idx]);
      end
    end
    set_mode = 1'b0; set_minute = 1'b0;
  endtask

  task automatic test_mid_slot();
    set_time_123456();
    set_mode = 1'b0;
    restart();
    wait_to(30);
    second_l = 4'd7;
    wait_to(32);
    n_cmp++;
    if (seg !== 8'h82 || dig !== 6'h3E) begin
      n_fail++; $display("FAIL mid_slot_hold: seg=%h dig=%h want 82/3e", seg, dig);
    end
    wait_to(34);
    n_cmp++;
    if (seg !== 8'h92) begin
      n_fail++; $display("FAIL mid_slot_next: seg=%h want 92", seg);
    end
    wait_to(54);
    n_cmp++;
    if (seg !== 8'hF8 || dig !== 6'h3E) begin
      n_fail++; $display("FAIL mid_slot_new: seg=%h dig=%h want f8/3e", seg, dig);
    end
    second_l = 4'd6;
  endtask

  task automatic test_set_mode_drop();
    set_time_123456();
    set_mode = 1'b1; set_minute = 1'b1;
    restart();
    wait_to(38);
    n_cmp++;
    if (seg !== 8'h7F) begin
      n_fail++; $display("FAIL drop_blanked: seg=%h want 7f", seg);
    end
    set_mode = 1'b0;
    wait_to(40);
    n_cmp++;
    if (seg !== 8'h7F) begin
      n_fail++; $display("FAIL drop_held: seg=%h want 7f", seg);
    end
    wait_to(42);
    n_cmp++;
    if (seg !== 8'hB0 || dig !== 6'h37) begin
      n_fail++; $display("FAIL drop_unblanked: seg=%h dig=%h want b0/37", seg, dig);
    end
    set_minute = 1'b0;
  endtask

  task automatic test_async_reset();
    set_time_123456();
    set_mode = 1'b0;
    restart();
    wait_to(18);
    n_cmp++;
    if (dig !== 6'h37) begin
      n_fail++; $display("FAIL async_pre: dig=%h want 37", dig);
    end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (seg !== 8'hFF || dig !== 6'h3F) begin
      n_fail++; $display("FAIL async_reset: seg=%h dig=%h want ff/3f", seg, dig);
    end
    @(negedge clk);
    rst = 1'b1;
    wait_to(4);
    n_cmp++;
    if (dig !== 6'h3F) begin
      n_fail++; $display("FAIL async_early: dig=%h want 3f", dig);
    end
    wait_to(6);
    n_cmp++;
    if (seg !== 8'h82 || dig !== 6'h3E) begin
      n_fail++; $display("FAIL async_restart: seg=%h dig=%h want 82/3e", seg, dig);
    end
  endtask

  initial begin
    norm[0] = 8'h82; norm[1] = 8'h92; norm[2] = 8'h19;
    norm[3] = 8'hB0; norm[4] = 8'h24; norm[5] = 8'hF9;
    digs[0] = 6'h3E; digs[1] = 6'h3D; digs[2] = 6'h3B;
    digs[3] = 6'h37; digs[4] = 6'h2F; digs[5] = 6'h1F;
    set_time_123456();
    set_mode = 1'b0; set_hour = 1'b0; set_minute = 1'b0; set_second = 1'b0;
    test_reset();
    test_decode();
    test_invalid_bcd();
    test_blink();
    test_mid_slot();
    test_set_mode_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
